// File: rtl/adrv9001_hop_sequencer.sv
// Frequency-hop sequencer for ADRV9001 TX1/TX2/RX1/RX2 enables and the hop DGPIO pin.
// Optional HOP_TRIG_SYNC_EN: synchronize and edge-detect hop_trig_pl before qualification.
module adrv9001_hop_sequencer #(
  parameter int DELAY_WIDTH = 24
) (
  input  logic                   s_axi_aclk,
  input  logic                   s_axi_aresetn,
  input  logic                   hopping_mode,
  input  logic [3:0]             manual_enable,
  input  logic                   hop_trig_ps,
  input  logic                   hop_trig_pl,
  input  logic                   enable_pl_hop_trig,
  input  logic                   hop_trig_enable,
  input  logic                   hop_trig_clear,
  input  logic [3:0]             next_hop_enable_mask,
  input  logic [DELAY_WIDTH-1:0] tx1_setup_dly,
  input  logic [DELAY_WIDTH-1:0] tx2_setup_dly,
  input  logic [DELAY_WIDTH-1:0] rx1_setup_dly,
  input  logic [DELAY_WIDTH-1:0] rx2_setup_dly,
  input  logic [DELAY_WIDTH-1:0] hop_dgpio_dly,
  output logic [3:0]             chan_enable,
  output logic                   hop_dgpio,
  output logic                   busy,
  output logic                   hop_trig_status,
  output logic [15:0]            hop_count,
  output logic [1:0]             state_dbg
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DGPIO_WAIT = 2'd1,
    SETUP      = 2'd2
  } state_t;

  localparam logic [DELAY_WIDTH-1:0] DLY_ONE = 1;

  state_t                 state, state_nxt;
  logic [DELAY_WIDTH-1:0] dcnt;
  logic [DELAY_WIDTH-1:0] scnt [4];
  logic [3:0]             nmask;
  logic [3:0]             done;
  logic [3:0]             ch_zero;
  logic                   setup_last;
  logic                   pl_trig;
  logic                   trig;

`ifdef HOP_TRIG_SYNC_EN
  // Two sync flops, a history flop, and a registered rising-edge pulse.
  logic pl_s1, pl_s2, pl_s3, pl_rise;

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      pl_s1   <= 1'b0;
      pl_s2   <= 1'b0;
      pl_s3   <= 1'b0;
      pl_rise <= 1'b0;
    end else begin
      pl_s1   <= hop_trig_pl;
      pl_s2   <= pl_s1;
      pl_s3   <= pl_s2;
      pl_rise <= pl_s2 & ~pl_s3;
    end
  end

  assign pl_trig = pl_rise;
`else
  assign pl_trig = hop_trig_pl;
`endif

  assign trig = hop_trig_enable & hopping_mode &
                (hop_trig_ps | (enable_pl_hop_trig & pl_trig));

  // A channel finishes on the edge its counter reads zero; exit when none remain.
  always_comb begin
    ch_zero = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      ch_zero[i] = (scnt[i] == '0);
    end
    setup_last = &(done | ch_zero);
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (trig) state_nxt = DGPIO_WAIT;
      end
      DGPIO_WAIT: begin
        if (!hopping_mode)     state_nxt = IDLE;
        else if (dcnt == '0)   state_nxt = SETUP;
      end
      SETUP: begin
        if (!hopping_mode || setup_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    state_dbg = state;
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      chan_enable     <= 4'b0000;
      hop_dgpio       <= 1'b0;
      hop_trig_status <= 1'b0;
      hop_count       <= 16'd0;
      dcnt            <= '0;
      nmask           <= 4'b0000;
      done            <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        scnt[i] <= '0;
      end
    end else begin
      // A trigger arriving mid-hop is only recorded; set beats a same-cycle clear.
      if (trig && (state != IDLE)) begin
        hop_trig_status <= 1'b1;
      end else if (hop_trig_clear) begin
        hop_trig_status <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (trig) begin
            chan_enable <= 4'b0000;
            nmask       <= next_hop_enable_mask;
            dcnt        <= hop_dgpio_dly;
          end else if (!hopping_mode) begin
            chan_enable <= manual_enable;
          end
        end
        DGPIO_WAIT: begin
          if (!hopping_mode) begin
            chan_enable <= manual_enable;
          end else if (dcnt == '0) begin
            hop_dgpio <= ~hop_dgpio;
            scnt[3]   <= tx1_setup_dly;
            scnt[2]   <= tx2_setup_dly;
            scnt[1]   <= rx1_setup_dly;
            scnt[0]   <= rx2_setup_dly;
            done      <= ~nmask;
          end else begin
            dcnt <= dcnt - DLY_ONE;
          end
        end
        SETUP: begin
          if (!hopping_mode) begin
            chan_enable <= manual_enable;
          end else begin
            for (int i = 0; i < 4; i++) begin
              if (!done[i]) begin
                if (ch_zero[i]) begin
                  chan_enable[i] <= 1'b1;
                  done[i]        <= 1'b1;
                end else begin
                  scnt[i] <= scnt[i] - DLY_ONE;
                end
              end
            end
            if (setup_last) hop_count <= hop_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adrv9001_hop_sequencer.sv
// Bench for adrv9001_hop_sequencer: directed and random stimulus against an event-time model.
// Build with HOP_TRIG_SYNC_EN defined to cover the synchronized PL trigger path.
module tb_adrv9001_hop_sequencer;

  localparam int DW = 24;
  localparam int W  = 23;

  // ---------------- clock / reset ----------------
  logic s_axi_aclk = 1'b0;
  always #5 s_axi_aclk = ~s_axi_aclk;

  logic          s_axi_aresetn;
  logic          hopping_mode;
  logic [3:0]    manual_enable;
  logic          hop_trig_ps;
  logic          hop_trig_pl;
  logic          enable_pl_hop_trig;
  logic          hop_trig_enable;
  logic          hop_trig_clear;
  logic [3:0]    next_hop_enable_mask;
  logic [DW-1:0] tx1_setup_dly, tx2_setup_dly, rx1_setup_dly, rx2_setup_dly;
  logic [DW-1:0] hop_dgpio_dly;
  logic [3:0]    chan_enable;
  logic          hop_dgpio;
  logic          busy;
  logic          hop_trig_status;
  logic [15:0]   hop_count;
  logic [1:0]    state_dbg;

  adrv9001_hop_sequencer #(.DELAY_WIDTH(DW)) dut (
    .s_axi_aclk           (s_axi_aclk),
    .s_axi_aresetn        (s_axi_aresetn),
    .hopping_mode         (hopping_mode),
    .manual_enable        (manual_enable),
    .hop_trig_ps          (hop_trig_ps),
    .hop_trig_pl          (hop_trig_pl),
    .enable_pl_hop_trig   (enable_pl_hop_trig),
    .hop_trig_enable      (hop_trig_enable),
    .hop_trig_clear       (hop_trig_clear),
    .next_hop_enable_mask (next_hop_enable_mask),
    .tx1_setup_dly        (tx1_setup_dly),
    .tx2_setup_dly        (tx2_setup_dly),
    .rx1_setup_dly        (rx1_setup_dly),
    .rx2_setup_dly        (rx2_setup_dly),
    .hop_dgpio_dly        (hop_dgpio_dly),
    .chan_enable          (chan_enable),
    .hop_dgpio            (hop_dgpio),
    .busy                 (busy),
    .hop_trig_status      (hop_trig_status),
    .hop_count            (hop_count),
    .state_dbg            (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           exp_t_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] mon_e, mon_a;
  int           mon_t;

  // ---------------- reference model ----------------
  // A hop is described by its trigger edge k, N and per-channel S; outputs follow from edge arithmetic.
  int          t = 0;
  logic [3:0]  m_en = 4'b0;
  logic        m_dgpio = 1'b0, m_active = 1'b0, m_status = 1'b0;
  logic [15:0] m_count = 16'd0;
  int          hk = 0, hn = 0, hend = 0;
  int          hs[4];
  logic [3:0]  hmask = 4'b0;
`ifdef HOP_TRIG_SYNC_EN
  logic [3:0]  m_pl_hist = 4'b0;
`endif

  task automatic model_edge();
    logic pl_eff;
    logic mtrig;
    int   mx;
`ifdef HOP_TRIG_SYNC_EN
    pl_eff = m_pl_hist[2] & ~m_pl_hist[3];
`else
    pl_eff = hop_trig_pl;
`endif
    mtrig = hop_trig_enable & hopping_mode &
            (hop_trig_ps | (enable_pl_hop_trig & pl_eff));
    if (!s_axi_aresetn) begin
      m_en = 4'b0; m_dgpio = 1'b0; m_active = 1'b0; m_status = 1'b0; m_count = 16'd0;
`ifdef HOP_TRIG_SYNC_EN
      m_pl_hist = 4'b0;
`endif
    end else begin
`ifdef HOP_TRIG_SYNC_EN
      m_pl_hist = {m_pl_hist[2:0], hop_trig_pl};
`endif
      if (m_active) begin
        if (mtrig) m_status = 1'b1;
        else if (hop_trig_clear) m_status = 1'b0;
        if (!hopping_mode) begin
          m_active = 1'b0;
          m_en     = manual_enable;
        end else if (t == hk + 1 + hn) begin
          m_dgpio = ~m_dgpio;
          hs[3] = int'(tx1_setup_dly);
          hs[2] = int'(tx2_setup_dly);
          hs[1] = int'(rx1_setup_dly);
          hs[0] = int'(rx2_setup_dly);
          mx = 0;
          for (int i = 0; i < 4; i++) if (hmask[i] && hs[i] > mx) mx = hs[i];
          hend = hk + 2 + hn + mx;
        end else if (t >= hk + 2 + hn) begin
          for (int i = 0; i < 4; i++) if (hmask[i] && t == hk + 2 + hn + hs[i]) m_en[i] = 1'b1;
          if (t == hend) begin
            m_active = 1'b0;
            m_count  = m_count + 16'd1;
          end
        end
      end else begin
        if (hop_trig_clear) m_status = 1'b0;
        if (mtrig) begin
          m_en     = 4'b0;
          m_active = 1'b1;
          hk       = t;
          hn       = int'(hop_dgpio_dly);
          hmask    = next_hop_enable_mask;
          hend     = -1;
        end else if (!hopping_mode) begin
          m_en = manual_enable;
        end
      end
    end
    exp_q.push_back({m_en, m_dgpio, m_active, m_status, m_count});
    exp_t_q.push_back(t);
    t++;
  endtask

  // ---------------- monitor ----------------
  always @(posedge s_axi_aclk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_t = exp_t_q.pop_front();
      mon_a = {chan_enable, hop_dgpio, busy, hop_trig_status, hop_count};
      n_cmp++;
      if (mon_a !== mon_e) begin
        n_err++;
        $display("FAIL outputs edge %0d: got en=%b dgpio=%b busy=%b status=%b count=%0d, required en=%b dgpio=%b busy=%b status=%b count=%0d",
                 mon_t, mon_a[22:19], mon_a[18], mon_a[17], mon_a[16], mon_a[15:0],
                 mon_e[22:19], mon_e[18], mon_e[17], mon_e[16], mon_e[15:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_edge();
    @(posedge s_axi_aclk);
    #2;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_ps();
    hop_trig_ps = 1'b1;
    tick();
    hop_trig_ps = 1'b0;
  endtask

  task automatic pulse_pl();
    hop_trig_pl = 1'b1;
    tick();
    hop_trig_pl = 1'b0;
  endtask

  task automatic set_delays(input int n, input int t1, input int t2, input int r1, input int r2);
    hop_dgpio_dly = DW'(n);
    tx1_setup_dly = DW'(t1);
    tx2_setup_dly = DW'(t2);
    rx1_setup_dly = DW'(r1);
    rx2_setup_dly = DW'(r2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    s_axi_aresetn = 1'b0; hopping_mode = 1'b0; manual_enable = 4'b0;
    hop_trig_ps = 1'b0; hop_trig_pl = 1'b0; enable_pl_hop_trig = 1'b0;
    hop_trig_enable = 1'b1; hop_trig_clear = 1'b0; next_hop_enable_mask = 4'b0;
    set_delays(0, 0, 0, 0, 0);
    run(3);
    s_axi_aresetn = 1'b1;

    // Pass-through
    manual_enable = 4'b1010;
    run(2);

    // Basic hop from 4'b1111, with an overrun, a clear and a clear+overrun collision
    manual_enable = 4'b1111;
    run(1);
    hopping_mode = 1'b1;
    next_hop_enable_mask = 4'b0101;
    set_delays(5, 7, 2, 3, 10);
    run(1);
    pulse_ps();
    hop_dgpio_dly = DW'(1);
    run(3);
    pulse_ps();
    run(2);
    hop_trig_clear = 1'b1; tick(); hop_trig_clear = 1'b0;
    run(2);
    hop_trig_clear = 1'b1; hop_trig_ps = 1'b1; tick();
    hop_trig_clear = 1'b0; hop_trig_ps = 1'b0;
    rx2_setup_dly = DW'(0);
    run(10);
    hop_trig_clear = 1'b1; tick(); hop_trig_clear = 1'b0;

    // Zero delays, full mask then empty mask
    set_delays(0, 0, 0, 0, 0);
    next_hop_enable_mask = 4'b1111;
    pulse_ps(); run(4);
    next_hop_enable_mask = 4'b0000;
    pulse_ps(); run(4);

    // Trigger gating
    next_hop_enable_mask = 4'b0110;
    set_delays(2, 1, 3, 1, 1);
    enable_pl_hop_trig = 1'b1; hop_trig_enable = 1'b0;
    pulse_pl(); run(6);
    hop_trig_enable = 1'b1; enable_pl_hop_trig = 1'b0;
    pulse_pl(); run(6);
    enable_pl_hop_trig = 1'b1;
    pulse_pl(); run(12);

    // Held PL level
    hop_trig_pl = 1'b1; run(50);
    hop_trig_pl = 1'b0; run(15);
    enable_pl_hop_trig = 1'b0;

    // Reset at k+8 of the basic hop
    next_hop_enable_mask = 4'b0101;
    set_delays(5, 7, 2, 3, 10);
    pulse_ps(); run(7);
    s_axi_aresetn = 1'b0; tick(); s_axi_aresetn = 1'b1;
    run(2);

    // hopping_mode dropped in SETUP
    manual_enable = 4'b0011;
    pulse_ps(); run(8);
    hopping_mode = 1'b0; tick();
    manual_enable = 4'b1001; run(2);
    hopping_mode = 1'b1; run(1);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      s_axi_aresetn        = ($urandom_range(0, 199) != 0);
      hop_trig_ps          = ($urandom_range(0, 14) == 0);
      hop_trig_pl          = ($urandom_range(0, 14) == 0);
      enable_pl_hop_trig   = 1'($urandom_range(0, 1));
      hop_trig_enable      = ($urandom_range(0, 7) != 0);
      hop_trig_clear       = ($urandom_range(0, 9) == 0);
      manual_enable        = 4'($urandom_range(0, 15));
      next_hop_enable_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) hopping_mode = ~hopping_mode;
      set_delays($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6),
                 $urandom_range(0, 6), $urandom_range(0, 6));
      tick();
    end
    hop_trig_ps = 1'b0; hop_trig_pl = 1'b0; s_axi_aresetn = 1'b1;
    run(20);

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
